// File: rtl/pipe_cla_adder_pkg.sv
// pipe_cla_adder_pkg: shared default geometry for the pipelined carry-lookahead adder.
package pipe_cla_adder_pkg;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_SEG    = 4;
    localparam int DEF_STAGES = 4;
endpackage

// File: rtl/pipe_cla_adder_cla_group.sv
// cla_group: SEG-bit generate/propagate lookahead group with carry-out and carry into its top bit.
module cla_group
    import pipe_cla_adder_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           cmsb
);
    logic [SEG-1:0] p, g;
    logic [SEG:0] c;
    logic t, acc;

    assign p = a ^ b;
    assign g = a & b;

    // each carry is a flat sum of products over the lower generate/propagate terms
    always_comb begin
        c = '0;
        t = 1'b1;
        acc = 1'b0;
        for (int i = 0; i <= SEG; i++) begin
            t = 1'b1;
            acc = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (g[j] & t);
                t = t & p[j];
            end
            c[i] = acc | (cin & t);
        end
    end

    assign sum  = p ^ c[SEG-1:0];
    assign cout = c[SEG];
    assign cmsb = c[SEG-1];
endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: valid/ready pipelined adder/subtractor, one WIDTH/STAGES slice of
// lookahead groups per stage with the slice carry registered into the next stage.
module pipe_cla_adder
    import pipe_cla_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SEG    = DEF_SEG,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             cmsb,
    output logic             ovf,
    output logic             zero
);
    localparam int SW = WIDTH / STAGES;
    localparam int G  = SW / SEG;
    localparam int L  = STAGES - 1;

    if (WIDTH % (SEG * STAGES) != 0) begin : g_bad_geometry
        $error("pipe_cla_adder: WIDTH must be a multiple of SEG*STAGES");
    end

    logic adv;
    logic [WIDTH-1:0] xa [STAGES], xb [STAGES], xs [STAGES], ns [STAGES];
    logic xv [STAGES], xc [STAGES], nc [STAGES], nm [STAGES];
    logic [WIDTH-1:0] ra [STAGES], rb [STAGES], rs [STAGES];
    logic rv [STAGES], rc [STAGES], rm [STAGES];

    assign adv       = !rv[L] || out_ready;
    assign in_ready  = adv;
    assign out_valid = rv[L];
    assign sum       = rs[L];
    assign cout      = rc[L];
    assign cmsb      = rm[L];
    assign ovf       = rc[L] ^ rm[L];
    assign zero      = ~|rs[L];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [G:0] c;
        logic [G-1:0] m;
        logic [SW-1:0] s;
        logic unused_m;
        if (k == 0) begin : g_head
            // subtraction is folded in here: later stages only ever add
            assign xv[k] = in_valid;
            assign xa[k] = a;
            assign xb[k] = sub ? ~b : b;
            assign xs[k] = '0;
            assign xc[k] = sub | cin;
        end else begin : g_body
            assign xv[k] = rv[k-1];
            assign xa[k] = ra[k-1];
            assign xb[k] = rb[k-1];
            assign xs[k] = rs[k-1];
            assign xc[k] = rc[k-1];
        end
        assign c[0] = xc[k];
        for (genvar j = 0; j < G; j++) begin : g_grp
            cla_group #(.SEG(SEG)) u_grp (
                .a   (xa[k][k*SW + j*SEG +: SEG]),
                .b   (xb[k][k*SW + j*SEG +: SEG]),
                .cin (c[j]),
                .sum (s[j*SEG +: SEG]),
                .cout(c[j+1]),
                .cmsb(m[j])
            );
        end
        // bits above the current slice are still zero in the partial sum
        assign ns[k]    = xs[k] | (WIDTH'(s) << (k * SW));
        assign nc[k]    = c[G];
        assign nm[k]    = m[G-1];
        assign unused_m = ^m;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                rv[k] <= 1'b0;
                rs[k] <= '0;
                rc[k] <= 1'b0;
                rm[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                rv[k] <= xv[k];
                rs[k] <= ns[k];
                rc[k] <= nc[k];
                rm[k] <= nm[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= xa[k];
                rb[k] <= xb[k];
            end
        end
    end
endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb_pipe_cla_adder: directed checks on the default adder plus randomized scoreboard runs
// on three geometries against an arithmetic reference model.
module tb_pipe_cla_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, cmsb, ovf, zero;
    logic [15:0] a, b, sum;
    logic [35:0] obs;
    int n_chk = 0, n_fail = 0, n_done = 0;

    assign obs = {zero, ovf, cmsb, cout, 16'h0, sum};

    pipe_cla_adder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .cmsb(cmsb), .ovf(ovf), .zero(zero)
    );

    // returns {zero, ovf, cmsb, cout, sum zero-extended to 32 bits}
    function automatic logic [35:0] ref_add(input int w, input longint av, input longint bv,
                                            input logic ci, input logic sb);
        longint m    = (64'sd1 <<< w) - 1;
        longint h    = m >>> 1;
        longint bx   = sb ? (~bv & m) : bv;
        longint c0   = sb ? 64'sd1 : {63'd0, ci};
        longint full = av + bx + c0;
        longint s    = full & m;
        longint sa   = (av > h) ? av - (m + 1) : av;
        longint sbv  = (bv > h) ? bv - (m + 1) : bv;
        longint tr   = sb ? sa - sbv : sa + sbv + {63'd0, ci};
        logic co     = ((full >>> w) & 1) != 0;
        logic cm     = ((((av & h) + (bx & h) + c0) >>> (w - 1)) & 1) != 0;
        logic of     = (tr > h) || (tr < -(h + 1));
        return {s == 0, of, cm, co, s[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic one(input string nm, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb, input logic [35:0] exp);
        int n = 1;
        in_valid = 1; a = av; b = bv; cin = ci; sub = sb; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0; a = 16'($urandom); b = 16'($urandom);
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd4);
        chk(nm, {28'd0, obs}, {28'd0, exp});
    endtask

    initial begin
        int k, nv, t;
        logic tk;
        logic [35:0] hv, ex[10];
        logic [15:0] ba[10], bb[10];
        logic bc[10], bs[10];
        rst = 0; in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0; sub = 0;
        #1 rst = 1;
        #2;
        chk("reset_outputs", {27'd0, out_valid, in_ready, obs}, {27'd0, 1'b0, 1'b1, 36'h8_0000_0000});
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("release_in_ready", 64'(in_ready), 64'd1);

        chk("model_7fff_plus_1", {28'd0, ref_add(16, 'h7FFF, 'h0001, 0, 0)}, {28'd0, 36'h6_0000_8000});
        chk("model_8000_minus_1", {28'd0, ref_add(16, 'h8000, 'h0001, 0, 1)}, {28'd0, 36'h5_0000_7FFF});
        chk("model_0_minus_1", {28'd0, ref_add(16, 'h0000, 'h0001, 0, 1)}, {28'd0, 36'h0_0000_FFFF});
        chk("model_ffff_plus_cin", {28'd0, ref_add(16, 'hFFFF, 'h0000, 1, 0)}, {28'd0, 36'hB_0000_0000});

        one("add_7fff_1", 16'h7FFF, 16'h0001, 0, 0, 36'h6_0000_8000);
        one("sub_8000_1", 16'h8000, 16'h0001, 1, 1, 36'h5_0000_7FFF);
        one("sub_0_1", 16'h0000, 16'h0001, 0, 1, 36'h0_0000_FFFF);
        one("add_ffff_cin", 16'hFFFF, 16'h0000, 1, 0, 36'hB_0000_0000);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            ba[i] = 16'($urandom); bb[i] = 16'($urandom);
            bc[i] = 1'($urandom); bs[i] = 1'($urandom);
            ex[i] = ref_add(16, {48'd0, ba[i]}, {48'd0, bb[i]}, bc[i], bs[i]);
        end
        out_ready = 0; k = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1; a = ba[k]; b = bb[k]; cin = bc[k]; sub = bs[k];
            @(negedge clk) tk = in_ready;
            @(posedge clk); #1;
            if (tk) k++;
        end
        chk("stall_accepted", 64'(k), 64'd4);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        hv = obs;
        @(posedge clk); #1;
        chk("stall_hold", {27'd0, out_valid, obs}, {27'd0, 1'b1, hv});
        chk("stall_head", {28'd0, obs}, {28'd0, ex[0]});
        out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            in_valid = k < 10;
            if (k < 10) begin a = ba[k]; b = bb[k]; cin = bc[k]; sub = bs[k]; end
            @(negedge clk);
            chk($sformatf("stream_%0d", c), {27'd0, out_valid, obs}, {27'd0, 1'b1, ex[c]});
            tk = in_valid && in_ready;
            @(posedge clk); #1;
            if (tk) k++;
        end
        in_valid = 0;
        chk("stream_all_accepted", 64'(k), 64'd10);

        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 0;
        @(posedge clk); #1;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #1 rst = 1;
        #1;
        chk("reset_midflight", {27'd0, out_valid, in_ready, obs}, {27'd0, 1'b0, 1'b1, 36'h8_0000_0000});
        @(posedge clk); #1;
        rst = 0; out_ready = 1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        nv = 0;
        repeat (6) begin
            @(negedge clk) nv += int'(out_valid);
            @(posedge clk); #1;
        end
        chk("no_stale_beat", 64'(nv), 64'd0);
        one("post_reset_beat", 16'h1234, 16'h4321, 0, 1, ref_add(16, 'h1234, 'h4321, 0, 1));

        t = 0;
        while (n_done < 3 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("random_runs_done", 64'(n_done), 64'd3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    for (genvar i = 0; i < 3; i++) begin : g_rand
        localparam int W  = (i == 2) ? 32 : 16;
        localparam int ST = (i == 0) ? 4 : (i == 1) ? 1 : 2;
        logic rst_g, iv, ir, ovl, ordy, ci, sb, co, cm, of, zr, pv, po;
        logic [W-1:0] ga, gb, gs;
        logic [35:0] gobs, pobs;
        logic [35:0] q[$];

        assign gobs = {zr, of, cm, co, 32'(gs)};

        pipe_cla_adder #(.WIDTH(W), .SEG(4), .STAGES(ST)) u_dut (
            .clk(clk), .rst(rst_g), .in_valid(iv), .in_ready(ir), .a(ga), .b(gb),
            .cin(ci), .sub(sb), .out_valid(ovl), .out_ready(ordy), .sum(gs),
            .cout(co), .cmsb(cm), .ovf(of), .zero(zr)
        );

        initial begin
            rst_g = 0; iv = 0; ordy = 1; ga = '0; gb = '0; ci = 0; sb = 0;
            pv = 0; po = 0; pobs = '0;
            #1 rst_g = 1;
            repeat (2) @(posedge clk);
            #1 rst_g = 0;
            for (int c = 0; c < 3000; c++) begin
                if (c == 1500) begin
                    rst_g = 1;
                    @(posedge clk); #1;
                    rst_g = 0;
                end
                iv   = $urandom_range(0, 9) < 7;
                ordy = $urandom_range(0, 9) < 6;
                ga   = W'({$urandom, $urandom});
                gb   = W'({$urandom, $urandom});
                ci   = 1'($urandom);
                sb   = 1'($urandom);
                @(posedge clk); #1;
            end
            iv = 0; ordy = 1;
            repeat (ST + 3) @(posedge clk);
            #1;
            chk($sformatf("cfg%0d_drained", i), 64'(q.size()), 64'd0);
            n_done++;
        end

        always @(negedge clk) begin
            if (rst_g) begin
                q.delete();
                pv <= 1'b0;
            end else begin
                chk($sformatf("cfg%0d_in_ready", i), 64'(ir), 64'(!ovl || ordy));
                if (pv && !po)
                    chk($sformatf("cfg%0d_hold", i), {27'd0, ovl, gobs}, {27'd0, 1'b1, pobs});
                if (ovl && ordy) begin
                    if (q.size() == 0)
                        chk($sformatf("cfg%0d_unexpected_beat", i), 64'(ovl), 64'd0);
                    else
                        chk($sformatf("cfg%0d_result", i), {28'd0, gobs}, {28'd0, q.pop_front()});
                end
                if (iv && ir)
                    q.push_back(ref_add(W, longint'(ga), longint'(gb), ci, sb));
                pv <= ovl;
            end
            po <= ordy;
            pobs <= gobs;
        end
    end
endmodule
